// File: rtl/quad_7seg_pkg.sv
// Shared constants for the four-digit multiplexed seven-segment driver:
// the ABCDEFG segment table, the overflow dash and the anode one-hot patterns.
package quad_7seg_pkg;

  // Index 0 is the rightmost entry of each concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  localparam logic [6:0] SEG_DASH = 7'b0000001;

  // Scan index 0 drives the leftmost digit.
  localparam logic [3:0][3:0] ANODE_ONEHOT = {4'b0001, 4'b0010, 4'b0100, 4'b1000};

  localparam logic [15:0] DEC_MAX = 16'd9999;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-digit to ABCDEFG segment decoder, active-high segments.
module seg7_decoder
  import quad_7seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/quad_7seg.sv
// Four-digit multiplexed seven-segment driver: registered input, prescaled
// digit scan, hex or decimal rendering and a registered anode/segment output.
module quad_7seg
  import quad_7seg_pkg::*;
#(
  parameter int HEX_MODE = 1,
  parameter int SCAN_DIV = 27000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] number,
  input  logic        colonEnable,
  output logic [10:0] segDrivers
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [15:0]      num_q;
  logic [CNT_W-1:0] prescale;
  logic [1:0]       scan_idx;
  logic [15:0]      bcd;
  logic [15:0]      digits;
  logic [3:0]       digit;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_next;
  logic             unused_colon;

  // The colon has no display path yet.
  assign unused_colon = colonEnable;

  // Double-dabble; only four BCD digits are kept since values above 9999 show dashes.
  function automatic logic [15:0] bin_to_bcd(input logic [15:0] bin);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int i = 15; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (acc[4*d +: 4] >= 4'd5) begin
          acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end else begin
          acc[4*d +: 4] = acc[4*d +: 4];
        end
      end
      acc = {acc[14:0], bin[i]};
    end
    return acc;
  endfunction

  // Input register, prescaler and scan index.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q    <= 16'h0000;
      prescale <= '0;
      scan_idx <= 2'd0;
    end else begin
      num_q <= number;
      if (prescale == CNT_LAST) begin
        prescale <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        prescale <= prescale + CNT_W'(1);
        scan_idx <= scan_idx;
      end
    end
  end

  assign bcd    = bin_to_bcd(num_q);
  assign digits = (HEX_MODE != 0) ? num_q : bcd;

  // Select the nibble of the active position, leftmost first.
  always_comb begin
    digit = 4'h0;
    case (scan_idx)
      2'd0:    digit = digits[15:12];
      2'd1:    digit = digits[11:8];
      2'd2:    digit = digits[7:4];
      2'd3:    digit = digits[3:0];
      default: digit = 4'h0;
    endcase
  end

  seg7_decoder u_dec (
    .digit (digit),
    .seg   (dec_seg)
  );

  // Out-of-range decimal values blank every position to a dash.
  always_comb begin
    seg_next = dec_seg;
    if ((HEX_MODE == 0) && (num_q > DEC_MAX)) begin
      seg_next = SEG_DASH;
    end else begin
      seg_next = dec_seg;
    end
  end

  // Anodes and segments leave the block together from one register.
  always_ff @(posedge clk) begin
    if (rst) begin
      segDrivers <= 11'b0;
    end else begin
      segDrivers <= {ANODE_ONEHOT[scan_idx], seg_next};
    end
  end

endmodule

// File: tb/tb_quad_7seg.sv
// Randomized bench for quad_7seg (hex and decimal instances, SCAN_DIV=4)
// against a slot-arithmetic reference model.
module tb_quad_7seg;

  localparam int SCAN = 4;

  logic        clk;
  logic        rst;
  logic [15:0] number;
  logic        colonEnable;
  logic [10:0] seg_hex;
  logic [10:0] seg_dec;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_active = 1'b0;
  int          m_k      = 0;
  logic [15:0] m_numq   = 16'h0000;
  logic [10:0] exp_hex;
  logic [10:0] exp_dec;

  logic [6:0] font [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  int pow10 [4] = '{1000, 100, 10, 1};

  quad_7seg #(.HEX_MODE(1), .SCAN_DIV(SCAN)) dut_hex (
    .clk(clk), .rst(rst), .number(number), .colonEnable(colonEnable), .segDrivers(seg_hex)
  );

  quad_7seg #(.HEX_MODE(0), .SCAN_DIV(SCAN)) dut_dec (
    .clk(clk), .rst(rst), .number(number), .colonEnable(colonEnable), .segDrivers(seg_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected display for a value at a position 0 (left) .. 3 (right).
  function automatic logic [10:0] model(input bit hex, input int val, input int pos);
    logic [3:0] an;
    logic [6:0] sg;
    an = 4'b1000 >> pos;
    if (hex) sg = font[(val / (1 << (4 * (3 - pos)))) % 16];
    else if (val > 9999) sg = 7'b0000001;
    else sg = font[(val / pow10[pos]) % 10];
    return {an, sg};
  endfunction

  task automatic cycle();
    int pos;
    @(posedge clk);
    if (rst) begin
      m_active = 1'b1;
      m_k      = 0;
      m_numq   = 16'h0000;
      exp_hex  = 11'b0;
      exp_dec  = 11'b0;
    end else if (m_active) begin
      m_k++;
      pos     = ((m_k - 1) / SCAN) % 4;
      exp_hex = model(1'b1, int'(m_numq), pos);
      exp_dec = model(1'b0, int'(m_numq), pos);
      m_numq  = number;
    end
    #1;
    if (m_active) begin
      check_eq("hex_out", seg_hex, exp_hex);
      check_eq("dec_out", seg_dec, exp_dec);
      if (m_k > 0) begin
        check_eq("hex_onehot", 11'($countones(seg_hex[10:7])), 11'd1);
        check_eq("dec_onehot", 11'($countones(seg_dec[10:7])), 11'd1);
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 4))
      0: return 16'($urandom_range(0, 9999));
      1: return 16'($urandom);
      2: return ($urandom_range(0, 1) != 0) ? 16'd9999 : 16'd10000;
      3: return ($urandom_range(0, 1) != 0) ? 16'h0000 : 16'hFFFF;
      default: return 16'($urandom_range(9990, 10010));
    endcase
  endfunction

  initial begin
    rst = 1'b1; number = 16'h0000; colonEnable = 1'b0;
    run(2);
    rst = 1'b0;
    run(20);
    number = 16'hA7B0;
    run(18);
    number = 16'h37CB;
    run(21);
    number = 16'd1234;
    run(18);
    number = 16'd10000;
    run(18);
    number = 16'd9999;
    run(10);
    // Reset pulse while the third digit is being scanned.
    for (int i = 0; i < 16; i++) begin
      if (((m_k / SCAN) % 4) == 2) break;
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(20);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) number = pick();
      colonEnable = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    run(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
